// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core-side and memory-side bundles for the load/store unit
// Core bundle: the pipeline is master and the LSU is slave. Memory bundle: the LSU is master.
interface load_store_unit_core_if #(parameter int BUS_WIDTH = 32);
    logic                 req_valid;
    logic                 req_write;
    logic [1:0]           req_size;
    logic                 req_unsigned;
    logic [BUS_WIDTH-1:0] addr;
    logic [BUS_WIDTH-1:0] wdata;
    logic                 stall;
    logic                 done;
    logic                 misaligned;
    logic [BUS_WIDTH-1:0] rdata;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, addr, wdata,
        input  stall, done, misaligned, rdata
    );
    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, addr, wdata,
        output stall, done, misaligned, rdata
    );
endinterface

interface load_store_unit_mem_if #(parameter int BUS_WIDTH = 32);
    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic                 mem_we;
    logic [BUS_WIDTH-1:0] mem_addr;
    logic [3:0]           mem_be;
    logic [BUS_WIDTH-1:0] mem_wdata;
    logic                 mem_rsp_valid;
    logic [BUS_WIDTH-1:0] mem_rsp_data;

    modport master (
        output mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data
    );
    modport slave (
        input  mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-access stage: aligned byte/half/word loads and stores over a valid/ready bus
// Misaligned accesses are rejected in IDLE and never reach memory.
module load_store_unit #(
    parameter int BUS_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    load_store_unit_core_if.slave  core,
    load_store_unit_mem_if.master  mem
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_e;

    state_e               state_q, state_d;
    logic                 we_q, we_d;
    logic [1:0]           size_q, size_d;
    logic                 uns_q, uns_d;
    logic [1:0]           off_q, off_d;
    logic [BUS_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]           be_q, be_d;
    logic [BUS_WIDTH-1:0] wdata_q, wdata_d;
    logic                 err_q, err_d;
    logic [BUS_WIDTH-1:0] rdata_q, rdata_d;

    logic                 misalign;
    logic [3:0]           be_next;
    logic [BUS_WIDTH-1:0] wdata_next;
    logic [BUS_WIDTH-1:0] lane;
    logic [BUS_WIDTH-1:0] load_ext;

    always_comb begin
        misalign   = 1'b0;
        be_next    = 4'b1111;
        wdata_next = core.wdata;
        case (core.req_size)
            2'b00: begin
                be_next    = 4'b0001 << core.addr[1:0];
                wdata_next = {4{core.wdata[7:0]}};
            end
            2'b01: begin
                misalign   = core.addr[0];
                be_next    = 4'b0011 << core.addr[1:0];
                wdata_next = {2{core.wdata[15:0]}};
            end
            default: misalign = |core.addr[1:0];
        endcase
    end

    // Lane select by byte offset, then extend from bit 7 or 15; word and reserved pass through.
    always_comb begin
        lane     = mem.mem_rsp_data >> {off_q, 3'b000};
        load_ext = mem.mem_rsp_data;
        case (size_q)
            2'b00: load_ext = {{(BUS_WIDTH-8){lane[7] & ~uns_q}}, lane[7:0]};
            2'b01: load_ext = {{(BUS_WIDTH-16){lane[15] & ~uns_q}}, lane[15:0]};
            default: load_ext = mem.mem_rsp_data;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (core.req_valid) begin
                    if (misalign) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        we_d    = core.req_write;
                        size_d  = core.req_size;
                        uns_d   = core.req_unsigned;
                        off_d   = core.addr[1:0];
                        addr_d  = {core.addr[BUS_WIDTH-1:2], 2'b00};
                        be_d    = be_next;
                        wdata_d = wdata_next;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem.mem_req_ready) begin
                    state_d = we_q ? DONE : WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (mem.mem_rsp_valid) begin
                    rdata_d = load_ext;
                    state_d = DONE;
                end
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign core.done       = (state_q == DONE);
    assign core.misaligned = (state_q == DONE) && err_q;
    assign core.stall      = core.req_valid && (state_q != DONE);
    assign core.rdata      = rdata_q;

    assign mem.mem_req_valid = (state_q == REQ);
    assign mem.mem_we        = we_q;
    assign mem.mem_addr      = addr_q;
    assign mem.mem_be        = be_q;
    assign mem.mem_wdata     = wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
// A small memory model answers requests with programmable ready and response delays.
module tb_load_store_unit;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    load_store_unit_core_if #(.BUS_WIDTH(32)) core_bus ();
    load_store_unit_mem_if  #(.BUS_WIDTH(32)) mem_bus ();

    load_store_unit #(.BUS_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .core  (core_bus),
        .mem   (mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          lat;
    logic        valid_seen;
    logic        stable;
    logic        stall_ok;
    logic        d_mis;
    logic        d_stall;
    logic [31:0] seen_addr;
    logic [31:0] seen_wdata;
    logic [3:0]  seen_be;
    logic        seen_we;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_access(input logic wr, input logic [1:0] sz, input logic un,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int rdy_dly, input int rsp_dly, input logic [31:0] rsp);
        int   cyc;
        int   waited;
        int   cnt;
        logic pending;
        logic finished;
        core_bus.req_valid    = 1'b1;
        core_bus.req_write    = wr;
        core_bus.req_size     = sz;
        core_bus.req_unsigned = un;
        core_bus.addr         = a;
        core_bus.wdata        = wd;
        valid_seen = 1'b0;
        stable     = 1'b1;
        stall_ok   = 1'b1;
        lat        = -1;
        d_mis      = 1'b0;
        d_stall    = 1'b1;
        waited     = 0;
        cnt        = 0;
        pending    = 1'b0;
        finished   = 1'b0;
        cyc        = 0;
        while (cyc < 40 && !finished) begin
            mem_bus.mem_req_ready = 1'b0;
            mem_bus.mem_rsp_valid = 1'b0;
            mem_bus.mem_rsp_data  = 32'hBAD0_BAD0;
            if (pending) begin
                if (cnt == 0) begin
                    mem_bus.mem_rsp_valid = 1'b1;
                    mem_bus.mem_rsp_data  = rsp;
                    pending = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (mem_bus.mem_req_valid) begin
                if (!valid_seen) begin
                    seen_addr  = mem_bus.mem_addr;
                    seen_wdata = mem_bus.mem_wdata;
                    seen_be    = mem_bus.mem_be;
                    seen_we    = mem_bus.mem_we;
                end else if (seen_addr !== mem_bus.mem_addr || seen_wdata !== mem_bus.mem_wdata ||
                             seen_be !== mem_bus.mem_be || seen_we !== mem_bus.mem_we) begin
                    stable = 1'b0;
                end
                valid_seen = 1'b1;
                if (waited >= rdy_dly) begin
                    mem_bus.mem_req_ready = 1'b1;
                    if (!mem_bus.mem_we) begin
                        pending = 1'b1;
                        cnt     = rsp_dly;
                    end
                end
                waited++;
            end
            #1;
            if (core_bus.done) begin
                lat      = cyc;
                finished = 1'b1;
                d_mis    = core_bus.misaligned;
                d_stall  = core_bus.stall;
            end else begin
                if (!core_bus.stall) stall_ok = 1'b0;
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        @(posedge clk);
        #1;
        core_bus.req_valid    = 1'b0;
        mem_bus.mem_req_ready = 1'b0;
        mem_bus.mem_rsp_valid = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        core_bus.req_valid    = 1'b0;
        core_bus.req_write    = 1'b0;
        core_bus.req_size     = 2'b00;
        core_bus.req_unsigned = 1'b0;
        core_bus.addr         = '0;
        core_bus.wdata        = '0;
        mem_bus.mem_req_ready = 1'b0;
        mem_bus.mem_rsp_valid = 1'b0;
        mem_bus.mem_rsp_data  = '0;
        seen_addr  = '0;
        seen_wdata = '0;
        seen_be    = '0;
        seen_we    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_done", core_bus.done, 0);
        check_eq("rst_mis", core_bus.misaligned, 0);
        check_eq("rst_stall", core_bus.stall, 0);
        check_eq("rst_rdata", core_bus.rdata, 0);
        check_eq("rst_mvalid", mem_bus.mem_req_valid, 0);
        check_eq("rst_we", mem_bus.mem_we, 0);
        check_eq("rst_addr", mem_bus.mem_addr, 0);
        check_eq("rst_be", mem_bus.mem_be, 0);
        check_eq("rst_wdata", mem_bus.mem_wdata, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF);
        check_eq("wl_lat", lat, 3);
        check_eq("wl_addr", seen_addr, 32'h100);
        check_eq("wl_be", seen_be, 4'b1111);
        check_eq("wl_we", seen_we, 0);
        check_eq("wl_stall_before", stall_ok, 1);
        check_eq("wl_stall_done", d_stall, 0);
        check_eq("wl_mis", d_mis, 0);
        check_eq("wl_rdata", core_bus.rdata, 32'hDEADBEEF);

        run_access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 0, 0, 32'h80FF_0000);
        check_eq("lb_addr", seen_addr, 32'h100);
        check_eq("lb_be", seen_be, 4'b1000);
        check_eq("lb_rdata", core_bus.rdata, 32'hFFFFFF80);

        run_access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 0, 0, 32'h80FF_0000);
        check_eq("lbu_rdata", core_bus.rdata, 32'h00000080);

        run_access(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234ABCD, 0, 0, 32'h0);
        check_eq("sh_lat", lat, 2);
        check_eq("sh_addr", seen_addr, 32'h20);
        check_eq("sh_be", seen_be, 4'b1100);
        check_eq("sh_wdata", seen_wdata, 32'hABCDABCD);
        check_eq("sh_we", seen_we, 1);
        check_eq("sh_rdata_kept", core_bus.rdata, 32'h00000080);

        run_access(1'b1, 2'b10, 1'b0, 32'h40, 32'h55AA1234, 3, 0, 32'h0);
        check_eq("bp_lat", lat, 5);
        check_eq("bp_stable", stable, 1);
        check_eq("bp_wdata", seen_wdata, 32'h55AA1234);
        check_eq("bp_be", seen_be, 4'b1111);

        run_access(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 0, 0, 32'h11111111);
        check_eq("mw_lat", lat, 1);
        check_eq("mw_mis", d_mis, 1);
        check_eq("mw_noreq", valid_seen, 0);
        check_eq("mw_rdata_kept", core_bus.rdata, 32'h00000080);

        run_access(1'b1, 2'b01, 1'b0, 32'h201, 32'hFFFF0000, 0, 0, 32'h0);
        check_eq("mh_lat", lat, 1);
        check_eq("mh_mis", d_mis, 1);
        check_eq("mh_noreq", valid_seen, 0);

        run_access(1'b0, 2'b01, 1'b0, 32'h106, 32'h0, 0, 2, 32'h8001_7FFF);
        check_eq("lh_lat", lat, 5);
        check_eq("lh_mis", d_mis, 0);
        check_eq("lh_be", seen_be, 4'b1100);
        check_eq("lh_rdata", core_bus.rdata, 32'hFFFF8001);

        run_access(1'b1, 2'b00, 1'b0, 32'h45, 32'hFFFFFF5A, 1, 0, 32'h0);
        check_eq("sb_lat", lat, 3);
        check_eq("sb_addr", seen_addr, 32'h44);
        check_eq("sb_be", seen_be, 4'b0010);
        check_eq("sb_wdata", seen_wdata, 32'h5A5A5A5A);

        core_bus.req_valid    = 1'b1;
        core_bus.req_write    = 1'b0;
        core_bus.req_size     = 2'b10;
        core_bus.req_unsigned = 1'b0;
        core_bus.addr         = 32'h300;
        @(posedge clk);
        #1;
        check_eq("rw_in_req", mem_bus.mem_req_valid, 1);
        mem_bus.mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_bus.mem_req_ready = 1'b0;
        core_bus.req_valid    = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("rw_done", core_bus.done, 0);
        check_eq("rw_rdata", core_bus.rdata, 0);
        check_eq("rw_mvalid", mem_bus.mem_req_valid, 0);
        check_eq("rw_addr", mem_bus.mem_addr, 0);
        check_eq("rw_be", mem_bus.mem_be, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mem_bus.mem_rsp_valid = 1'b1;
        mem_bus.mem_rsp_data  = 32'h12345678;
        @(posedge clk);
        #1;
        mem_bus.mem_rsp_valid = 1'b0;
        check_eq("rw_late_rdata", core_bus.rdata, 0);
        check_eq("rw_late_done", core_bus.done, 0);

        run_access(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 0, 0, 32'hCAFEF00D);
        check_eq("ra_lat", lat, 3);
        check_eq("ra_addr", seen_addr, 32'h104);
        check_eq("ra_rdata", core_bus.rdata, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage directly downstream of the ALU. It takes the ALU result as the effective address, plus store data and access size, and runs a valid/ready request and response transaction with data memory. It sign- or zero-extends load data into a register-width result and stalls the core while the access is outstanding. Byte, halfword and word accesses are supported. Misaligned accesses are flagged and never reach memory.

## Interface
- BUS_WIDTH, 32, datapath width; only 32 is supported (4 byte lanes).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  current instruction is a load/store; held until the cycle `done`=1.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- addr  in  BUS_WIDTH  effective address (ALU result).
- wdata  in  BUS_WIDTH  store data (rs2); low byte/half used for sub-word stores.
- stall  out  1  hold the PC and pipeline this cycle.
- done  out  1  one-cycle pulse: the access completed, or was rejected as misaligned.
- misaligned  out  1  qualifies `done`: the access was rejected.
- rdata  out  BUS_WIDTH  extended load result, held until the next load completes.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_we  out  1  request is a write.
- mem_addr  out  BUS_WIDTH  word-aligned address ({addr[31:2],2'b00}).
- mem_be  out  4  byte enables.
- mem_wdata  out  BUS_WIDTH  lane-replicated store data.
- mem_rsp_valid  in  1  read data valid (one cycle per read).
- mem_rsp_data  in  BUS_WIDTH  read data word.

## Operation
- FSM states: IDLE, REQ, WAIT_RSP, DONE. The reset state is IDLE.
- **IDLE**
  - On req_valid, the block checks alignment.
    - Halfword requires addr[0]=0.
    - Word (and reserved) requires addr[1:0]=00.
  - Misaligned: set the error flag and go to DONE. No memory transaction is issued.
  - Aligned:
    - Latch write, size, unsigned, addr[1:0] and word address.
    - Latch mem_be and the replicated wdata.
    - Go to REQ.
- **REQ**
  - mem_req_valid=1. mem_addr, mem_we, mem_be and mem_wdata are driven from the latched registers and are stable until handshake.
  - On mem_req_ready:
    - Store: go to DONE.
    - Load: go to WAIT_RSP.
  - Otherwise stay in REQ.
- **WAIT_RSP**
  - On mem_rsp_valid:
    - Select the lane using latched addr[1:0].
    - Extend per size and unsigned.
    - Register the result into rdata.
    - Go to DONE.
- **DONE**
  - done=1 for exactly one cycle. misaligned = error flag.
  - Unconditionally go to IDLE and clear the error flag.
- Byte enables:
  - Byte: 0001 << addr[1:0].
  - Half: 0011 << addr[1:0].
  - Word: 1111.
- Store data:
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: wdata.
- Loads are always issued with mem_be equal to the access mask.
- Load extension: the selected byte/half is extended from bit 7/15. Word loads are passed through.
- mem_rsp_valid outside WAIT_RSP is ignored.
- mem_req_ready outside REQ is ignored.

## Timing
- `stall` is combinational: req_valid && !done.
- The core advances on the edge where done=1. The next instruction's req_valid is sampled in the following IDLE cycle.
- Minimum latencies, counted from the first req_valid cycle to the done cycle:
  - Store: 2 cycles (ready in the first REQ cycle).
  - Load: 3 cycles (ready immediately, response the next cycle).
  - Misaligned: 1 cycle.
- Back-pressure: each cycle of mem_req_ready=0 in REQ adds one cycle. Each cycle of response delay adds one cycle.
- Reset values:
  - stall and done: 0.
  - misaligned: 0.
  - rdata: 0.
  - mem_req_valid: 0.
  - mem_we: 0.
  - mem_addr: 0.
  - mem_be: 0000.
  - mem_wdata: 0.
- Reset asserted mid-transaction:
  - The FSM returns to IDLE immediately (asynchronous).
  - The outstanding request is abandoned and mem_req_valid drops without handshake.
  - A late response is ignored and rdata is not updated.
- req_valid dropping before done is a protocol violation. The FSM still completes the latched transaction.
- rdata is updated only on the clock edge that enters DONE from WAIT_RSP. Stores and misaligned accesses leave it unchanged.

## Test plan
- **Word load, immediate ready, response next cycle**
  - Stimulus: addr=0x100, mem_rsp_data=0xDEADBEEF.
  - Required: mem_addr=0x100, be=1111; done in cycle 3 (stall=1 before it); rdata=0xDEADBEEF.
- **Signed byte load**
  - Stimulus: addr=0x103, mem_rsp_data=0x80FF_0000.
  - Required: rdata=0xFFFFFF80.
  - Repeat with req_unsigned=1: rdata=0x00000080.
- **Halfword store**
  - Stimulus: addr=0x22, wdata=0x1234ABCD.
  - Required: mem_addr=0x20, be=1100, mem_wdata=0xABCDABCD, mem_we=1; done 2 cycles after request.
- **Back-pressure**
  - Stimulus: word store with mem_req_ready low for 3 cycles.
  - Required: mem_req_valid and the address/data held stable throughout; done exactly 5 cycles after the request.
- **Misaligned accesses**
  - Stimulus: word load at addr=0x102; halfword store at addr=0x201.
  - Required: done=1 and misaligned=1 one cycle after the request; mem_req_valid never asserted; rdata unchanged.
- **Reset during WAIT_RSP**
  - Stimulus: drop rst_n while in WAIT_RSP; deliver mem_rsp_valid after reset is released.
  - Required: all outputs 0 and FSM in IDLE; the late response is ignored; a following load completes normally.
